// File: rtl/dot_matrix_scanner.sv
// rtl/dot_matrix_scanner.sv - column-multiplexed 5x3 dot-matrix scanner
// Double-buffered patterns; shadow->active transfer only at frame boundaries.
module dot_matrix_scanner #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [2:0] col_a,
  input  logic [2:0] col_b,
  input  logic [2:0] col_c,
  input  logic [2:0] col_d,
  input  logic [2:0] col_e,
  output logic [4:0] col_sel,
  output logic [2:0] row_n,
  output logic       frame_done,
  output logic       busy,
  output logic       pending
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam state_t           FIRST      = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       col_idx_q, col_idx_d;
  logic [14:0]      shadow_q, shadow_d;
  logic [14:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic [4:0]       col_sel_q, col_sel_d;
  logic [2:0]       row_n_q, row_n_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             boundary;
  logic [2:0]       col_pat;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_idx_d    = col_idx_q;
    frame_done_d = 1'b0;
    boundary     = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      col_idx_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          boundary  = 1'b1;
          col_idx_d = 3'd0;
          cnt_d     = '0;
          state_d   = FIRST;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d   = '0;
            state_d = FIRST;
            if (col_idx_q == 3'd4) begin
              col_idx_d    = 3'd0;
              boundary     = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              col_idx_d = col_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Transfer uses the pre-load shadow; a coincident load re-arms pending.
    active_d  = (boundary && pending_q) ? shadow_q : active_q;
    shadow_d  = load ? {col_e, col_d, col_c, col_b, col_a} : shadow_q;
    pending_d = load | (pending_q & ~boundary);

    case (col_idx_d)
      3'd0:    col_pat = active_d[2:0];
      3'd1:    col_pat = active_d[5:3];
      3'd2:    col_pat = active_d[8:6];
      3'd3:    col_pat = active_d[11:9];
      default: col_pat = active_d[14:12];
    endcase

    busy_d    = (state_d != IDLE);
    col_sel_d = 5'b00000;
    row_n_d   = 3'b111;
    if (state_d == SHOW) begin
      col_sel_d = 5'b00001 << col_idx_d;
      row_n_d   = ~col_pat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      col_idx_q    <= 3'd0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      col_sel_q    <= 5'b00000;
      row_n_q      <= 3'b111;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_idx_q    <= col_idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      col_sel_q    <= col_sel_d;
      row_n_q      <= row_n_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign col_sel    = col_sel_q;
  assign row_n      = row_n_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb/tb_dot_matrix_scanner.sv - scoreboard bench for dot_matrix_scanner
module tb_dot_matrix_scanner;

  typedef struct packed {
    logic [4:0] cs;
    logic [2:0] rn;
    logic       fd;
  } exp_t;

  localparam logic [14:0] P1   = 15'b111_101_101_101_111;
  localparam logic [14:0] P2   = 15'b110_011_100_010_001;
  localparam logic [14:0] ZERO = 15'b000_000_000_000_000;

  logic clk, rst_n, en0, en1, load;
  logic [2:0] col_a, col_b, col_c, col_d, col_e;
  logic [4:0] cs0, cs1;
  logic [2:0] rn0, rn1;
  logic fd0, fd1, busy0, busy1, pw0, pw1;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  dot_matrix_scanner #(.CLK_DIV(4), .BLANK_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .load(load),
    .col_a(col_a), .col_b(col_b), .col_c(col_c), .col_d(col_d), .col_e(col_e),
    .col_sel(cs0), .row_n(rn0), .frame_done(fd0), .busy(busy0), .pending(pw0)
  );

  dot_matrix_scanner #(.CLK_DIV(1), .BLANK_CYCLES(0), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .load(load),
    .col_a(col_a), .col_b(col_b), .col_c(col_c), .col_d(col_d), .col_e(col_e),
    .col_sel(cs1), .row_n(rn1), .frame_done(fd1), .busy(busy1), .pending(pw1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_cols(input logic [14:0] p);
    col_a = p[2:0];
    col_b = p[5:3];
    col_c = p[8:6];
    col_d = p[11:9];
    col_e = p[14:12];
  endtask

  task automatic push_frame(input logic [14:0] pat, input bit first);
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      e.cs = 5'b00000;
      e.rn = 3'b111;
      e.fd = (c == 0) && !first;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        e.cs = 5'(1 << c);
        e.rn = ~pat[c*3 +: 3];
        e.fd = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input logic [14:0] pat, input bit first, input int n,
                           input logic pend0, input logic pend_end,
                           input int la, input logic [14:0] lpa,
                           input int lb, input logic [14:0] lpb);
    exp_t e;
    push_frame(pat, first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load = 1'b0;
      e = exp_q.pop_front();
      check_eq("col_sel", 32'(cs0), 32'(e.cs));
      check_eq("row_n", 32'(rn0), 32'(e.rn));
      check_eq("frame_done", 32'(fd0), 32'(e.fd));
      check_eq("busy_scan", 32'(busy0), 32'd1);
      if (i == 0)  check_eq("pending_start", 32'(pw0), 32'(pend0));
      if (i == 24) check_eq("pending_end", 32'(pw0), 32'(pend_end));
      if (i == la) begin load = 1'b1; drive_cols(lpa); end
      if (i == lb) begin load = 1'b1; drive_cols(lpb); end
    end
    exp_q.delete();
  endtask

  initial begin
    exp_t e;
    clk = 1'b0; rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; load = 1'b0;
    drive_cols(ZERO);
    repeat (3) @(negedge clk);
    check_eq("reset_u0", {cs0, rn0, fd0, busy0, pw0}, {5'b00000, 3'b111, 3'b000});
    check_eq("reset_u1", {cs1, rn1, fd1, busy1, pw1}, {5'b00000, 3'b111, 3'b000});
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("idle_u0", {cs0, rn0, fd0, busy0, pw0}, {5'b00000, 3'b111, 3'b000});
    end

    load = 1'b1;
    drive_cols(P1);
    @(negedge clk);
    load = 1'b0;
    check_eq("pending_load", 32'(pw0), 32'd1);
    check_eq("idle_after_load", 32'(busy0), 32'd0);
    en0 = 1'b1;

    run_frame(P1,   1'b1, 25, 1'b0, 1'b0, -1, ZERO, -1, ZERO);
    run_frame(P1,   1'b0, 25, 1'b0, 1'b1, 11, ZERO, -1, ZERO);
    run_frame(ZERO, 1'b0, 25, 1'b0, 1'b0, -1, ZERO, -1, ZERO);
    run_frame(ZERO, 1'b0, 25, 1'b0, 1'b1,  5, P1,   24, P2);
    run_frame(P1,   1'b0, 25, 1'b1, 1'b1, -1, ZERO, -1, ZERO);
    run_frame(P2,   1'b0, 25, 1'b0, 1'b0, -1, ZERO, -1, ZERO);

    run_frame(P2,   1'b0, 17, 1'b0, 1'b0, -1, ZERO, -1, ZERO);
    en0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("en_drop", {cs0, rn0, fd0, busy0}, {5'b00000, 3'b111, 2'b00});
    end
    en0 = 1'b1;
    run_frame(P2,   1'b1, 25, 1'b0, 1'b0, -1, ZERO, -1, ZERO);

    check_eq("u1_pending_idle", 32'(pw1), 32'd1);
    en1 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      e.cs = 5'(1 << (i % 5));
      e.rn = ~P2[(i % 5)*3 +: 3];
      e.fd = (i >= 5) && (i % 5 == 0);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq("u1_col_sel", 32'(cs1), 32'(e.cs));
      check_eq("u1_row_n", 32'(rn1), 32'(e.rn));
      check_eq("u1_frame_done", 32'(fd1), 32'(e.fd));
    end
    check_eq("u1_pending_clr", 32'(pw1), 32'd0);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_u0", {cs0, rn0, fd0, busy0, pw0}, {5'b00000, 3'b111, 3'b000});
    check_eq("async_rst_u1", {cs1, rn1, fd1, busy1, pw1}, {5'b00000, 3'b111, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
